// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Hazard FSM state encoding
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    HALTED  = 2'b10
  } hz_state_e;

  // Default data-memory miss stall length (cycles), legal 1..15
  localparam int unsigned MEM_LAT_DEF = 4;

  // Register index width
  localparam int unsigned REG_IDX_W = 4;

  // Miss-wait timer width
  localparam int unsigned TMR_W = 4;

endpackage

// File: rtl/hazard_wait_timer.sv
// Miss-wait down-counter: load, decrement to zero without wrapping,
// flag the final wait cycle.
module hazard_wait_timer
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_expire
);

  logic [TMR_W-1:0] r_count;

  // Load has priority; decrement stops at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // The decrement in this cycle takes the count to zero, so this is the last wait cycle
  assign o_expire = (r_count <= TMR_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-miss
// freeze and halt handling.
// Build option: define HAZARD_STALL_CNT_EN to add the 16-bit stall_cnt output.
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | normal flow; load-use, branch and miss detection active
// MEMWAIT | data miss outstanding; whole pipeline frozen
// HALTED  | HLT retired; fetch held, pipeline flushed until reset
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 idex_memenable,
  input  logic                 idex_memwrite,
  input  logic [REG_IDX_W-1:0] idex_DstReg,
  input  logic [REG_IDX_W-1:0] ifid_SrcReg1,
  input  logic [REG_IDX_W-1:0] ifid_SrcReg2,
  input  logic                 ifid_uses_src2,
  input  logic                 branch_taken,
  input  logic                 mem_miss,
  input  logic                 halt_wb,
  output logic                 pc_freeze,
  output logic                 ifid_freeze,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 all_freeze,
`ifdef HAZARD_STALL_CNT_EN
  output logic [15:0]          stall_cnt,
`endif
  output logic                 halted
);

  hz_state_e r_state;
  hz_state_e w_state_nxt;
  logic      w_load_use;
  logic      w_tmr_load;
  logic      w_tmr_dec;
  logic      w_tmr_expire;

  assign w_load_use = idex_memenable && !idex_memwrite && (idex_DstReg != '0) &&
                      ((idex_DstReg == ifid_SrcReg1) ||
                       (ifid_uses_src2 && (idex_DstReg == ifid_SrcReg2)));

  assign w_tmr_load = (r_state == RUN) && mem_miss;
  assign w_tmr_dec  = (r_state == MEMWAIT);

  hazard_wait_timer u_wait_timer (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_tmr_load),
    .i_load_val (TMR_W'(MEM_LAT - 1)),
    .i_dec      (w_tmr_dec),
    .o_expire   (w_tmr_expire)
  );

  // Next-state selection; halt overrides everything
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        // A one-cycle latency is fully covered by the detection cycle
        if (mem_miss) w_state_nxt = (MEM_LAT == 1) ? RUN : MEMWAIT;
      end
      MEMWAIT: begin
        if (w_tmr_expire) w_state_nxt = RUN;
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
    if (halt_wb) w_state_nxt = HALTED;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pipeline controls from state and current inputs: miss > branch > load-use
  always_comb begin
    pc_freeze   = 1'b0;
    ifid_freeze = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    all_freeze  = 1'b0;
    halted      = 1'b0;
    case (r_state)
      RUN: begin
        if (mem_miss) begin
          all_freeze = 1'b1;
        end else if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_load_use) begin
          pc_freeze   = 1'b1;
          ifid_freeze = 1'b1;
          idex_flush  = 1'b1;
        end
      end
      MEMWAIT: all_freeze = 1'b1;
      HALTED: begin
        pc_freeze  = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        halted     = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles with the PC or the whole pipeline held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if ((pc_freeze || all_freeze) && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_LAT = 4).
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       idex_memenable;
  logic       idex_memwrite;
  logic [3:0] idex_DstReg;
  logic [3:0] ifid_SrcReg1;
  logic [3:0] ifid_SrcReg2;
  logic       ifid_uses_src2;
  logic       branch_taken;
  logic       mem_miss;
  logic       halt_wb;
  logic       pc_freeze;
  logic       ifid_freeze;
  logic       ifid_flush;
  logic       idex_flush;
  logic       all_freeze;
  logic       halted;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp;
  int n_err;

  // Output vector order: {pc_freeze, ifid_freeze, ifid_flush, idex_flush, all_freeze, halted}
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_LDUSE = 6'b110100;
  localparam logic [5:0] O_BR    = 6'b001100;
  localparam logic [5:0] O_FRZ   = 6'b000010;
  localparam logic [5:0] O_HALT  = 6'b101101;

  hazard_ctrl #(.MEM_LAT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .idex_memenable (idex_memenable),
    .idex_memwrite  (idex_memwrite),
    .idex_DstReg    (idex_DstReg),
    .ifid_SrcReg1   (ifid_SrcReg1),
    .ifid_SrcReg2   (ifid_SrcReg2),
    .ifid_uses_src2 (ifid_uses_src2),
    .branch_taken   (branch_taken),
    .mem_miss       (mem_miss),
    .halt_wb        (halt_wb),
    .pc_freeze      (pc_freeze),
    .ifid_freeze    (ifid_freeze),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .all_freeze     (all_freeze),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cnt      (stall_cnt),
`endif
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {10'd0, pc_freeze, ifid_freeze, ifid_flush, idex_flush, all_freeze, halted};
  endfunction

  // Drive one cycle's inputs just after the falling edge
  task automatic drive(input logic men, input logic mwr, input logic [3:0] dst,
                       input logic [3:0] s1, input logic [3:0] s2, input logic u2,
                       input logic br, input logic miss, input logic hlt);
    @(negedge clk);
    idex_memenable = men;
    idex_memwrite  = mwr;
    idex_DstReg    = dst;
    ifid_SrcReg1   = s1;
    ifid_SrcReg2   = s2;
    ifid_uses_src2 = u2;
    branch_taken   = br;
    mem_miss       = miss;
    halt_wb        = hlt;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idex_memenable = 0; idex_memwrite = 0; idex_DstReg = 0;
    ifid_SrcReg1 = 0; ifid_SrcReg2 = 0; ifid_uses_src2 = 0;
    branch_taken = 0; mem_miss = 0; halt_wb = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    idex_memenable = 0; idex_memwrite = 0; idex_DstReg = 0;
    ifid_SrcReg1 = 0; ifid_SrcReg2 = 0; ifid_uses_src2 = 0;
    branch_taken = 0; mem_miss = 0; halt_wb = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", outs(), {10'd0, O_IDLE});
`ifdef HAZARD_STALL_CNT_EN
    chk("reset_cnt", stall_cnt, 16'd0);
`endif
    rst = 1'b1;

    // Load-use on SrcReg1, then bubble in ID/EX
    drive(1, 0, 4'd3, 4'd3, 4'd7, 0, 0, 0, 0);
    chk("lu_src1", outs(), {10'd0, O_LDUSE});
    drive(0, 0, 4'd0, 4'd3, 4'd7, 0, 0, 0, 0);
    chk("lu_bubble", outs(), {10'd0, O_IDLE});

    // SrcReg2 matters only when used
    drive(1, 0, 4'd5, 4'd1, 4'd5, 1, 0, 0, 0);
    chk("lu_src2_used", outs(), {10'd0, O_LDUSE});
    drive(1, 0, 4'd5, 4'd1, 4'd5, 0, 0, 0, 0);
    chk("lu_src2_unused", outs(), {10'd0, O_IDLE});

    // R0 destination and store never stall
    drive(1, 0, 4'd0, 4'd0, 4'd0, 1, 0, 0, 0);
    chk("r0_no_stall", outs(), {10'd0, O_IDLE});
    drive(1, 1, 4'd3, 4'd3, 4'd0, 0, 0, 0, 0);
    chk("store_no_stall", outs(), {10'd0, O_IDLE});

    // Branch wins over load-use
    drive(1, 0, 4'd3, 4'd3, 4'd0, 0, 1, 0, 0);
    chk("br_over_lu", outs(), {10'd0, O_BR});

    // Miss pulse with branch held: 4 freeze cycles then the flush
    drive(1, 0, 4'd3, 4'd3, 4'd0, 0, 1, 1, 0);
    chk("miss_c1", outs(), {10'd0, O_FRZ});
    drive(1, 0, 4'd3, 4'd3, 4'd0, 0, 1, 1, 0);
    chk("miss_c2", outs(), {10'd0, O_FRZ});
    drive(1, 0, 4'd3, 4'd3, 4'd0, 0, 1, 0, 0);
    chk("miss_c3", outs(), {10'd0, O_FRZ});
    drive(1, 0, 4'd3, 4'd3, 4'd0, 0, 1, 0, 0);
    chk("miss_c4", outs(), {10'd0, O_FRZ});
    drive(1, 0, 4'd3, 4'd3, 4'd0, 0, 1, 0, 0);
    chk("miss_c5_br", outs(), {10'd0, O_BR});
    idle();
    chk("after_miss", outs(), {10'd0, O_IDLE});

    // Reset during MEMWAIT aborts the wait
    drive(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0);
    idle();
    chk("wait_before_rst", outs(), {10'd0, O_FRZ});
    do_reset();
    #1;
    chk("run_after_rst", outs(), {10'd0, O_IDLE});
    drive(1, 0, 4'd9, 4'd9, 4'd0, 0, 0, 0, 0);
    chk("lu_after_rst", outs(), {10'd0, O_LDUSE});

    // Halt during MEMWAIT, held until reset
    drive(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0);
    drive(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1);
    chk("wait_at_halt", outs(), {10'd0, O_FRZ});
    idle();
    chk("halted_1", outs(), {10'd0, O_HALT});
    drive(1, 0, 4'd3, 4'd3, 4'd0, 0, 1, 1, 0);
    chk("halted_2", outs(), {10'd0, O_HALT});
    idle();
    chk("halted_3", outs(), {10'd0, O_HALT});
    #1 rst = 1'b0;
    #1;
    chk("async_rst", outs(), {10'd0, O_IDLE});
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 4'd4, 4'd2, 4'd4, 1, 0, 0, 0);
    chk("lu_after_halt", outs(), {10'd0, O_LDUSE});

`ifdef HAZARD_STALL_CNT_EN
    // 3 load-use stalls plus a 4-cycle miss
    do_reset();
    #1;
    chk("cnt_cleared", stall_cnt, 16'd0);
    drive(1, 0, 4'd3, 4'd3, 4'd0, 0, 0, 0, 0);
    drive(1, 0, 4'd3, 4'd3, 4'd0, 0, 0, 0, 0);
    drive(1, 0, 4'd3, 4'd3, 4'd0, 0, 0, 0, 0);
    drive(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0);
    idle();
    idle();
    idle();
    idle();
    chk("cnt_seven", stall_cnt, 16'd7);
    idle();
    chk("cnt_hold", stall_cnt, 16'd7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 4: data-memory miss stall length in cycles, legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 idex_memenable  input  1  ID/EX instruction accesses memory.
REQ-005 idex_memwrite  input  1  ID/EX memory access is a store.
REQ-006 idex_DstReg  input  4  ID/EX destination register.
REQ-007 ifid_SrcReg1, ifid_SrcReg2  input  4 each  IF/ID source registers.
REQ-008 ifid_uses_src2  input  1  IF/ID instruction reads SrcReg2.
REQ-009 branch_taken  input  1  EX-resolved taken branch/jump.
REQ-010 mem_miss  input  1  data memory reports a miss this cycle.
REQ-011 halt_wb  input  1  HLT instruction at WB.
REQ-012 pc_freeze  output  1  hold PC.
REQ-013 ifid_freeze, ifid_flush  output  1 each  IF/ID register controls.
REQ-014 idex_flush  output  1  insert bubble into ID/EX.
REQ-015 all_freeze  output  1  freeze every pipeline register and PC.
REQ-016 halted  output  1  core stopped.

Function
REQ-017 FSM states: RUN, MEMWAIT, HALTED. All outputs are combinational from the state and the current-cycle inputs.
REQ-018 Load-use hazard (RUN only): idex_memenable & ~idex_memwrite & idex_DstReg!=0 & (DstReg==SrcReg1 | (ifid_uses_src2 & DstReg==SrcReg2)) SHALL assert pc_freeze, ifid_freeze and idex_flush in the same cycle; no registered state is involved.
REQ-019 branch_taken in RUN SHALL assert ifid_flush and idex_flush, SHALL suppress load-use outputs, and SHALL leave pc_freeze at 0.
REQ-020 mem_miss in RUN: next state MEMWAIT; timer loads MEM_LAT-1; all_freeze=1 in the detection cycle; all flush/freeze outputs except all_freeze forced to 0.
REQ-021 MEMWAIT: all_freeze=1; the timer decrements each cycle; at timer==0 the next state is RUN. all_freeze is high for exactly MEM_LAT consecutive cycles in total, counting the detection cycle.
REQ-022 In MEMWAIT, mem_miss, branch_taken and load-use are ignored. The branch source holds branch_taken because EX is frozen, so the branch is acted on the first RUN cycle after the wait.
REQ-023 halt_wb in any state: next state HALTED. HALTED asserts pc_freeze, ifid_flush, idex_flush and halted, and is left only by reset.
REQ-024 Priority: halt_wb > MEMWAIT/mem_miss > branch_taken > load-use.
REQ-025 The timer is 4 bits unsigned and never underflows. With MEM_LAT=1 the FSM returns to RUN after the detection cycle.

Reset
REQ-026 rst low SHALL immediately set state=RUN, timer=0, and the stall counter (if present) to 0. With inputs idle, all outputs are 0.
REQ-027 Reset asserted during MEMWAIT or HALTED SHALL abort the wait or halt; the first cycle after release is RUN.

Configuration
REQ-028 Macro HAZARD_STALL_CNT_EN defined: add output stall_cnt (16 bits). It increments by 1 each cycle in which pc_freeze or all_freeze is 1, saturates at 0xFFFF, and is reset to 0.
REQ-029 Macro HAZARD_STALL_CNT_EN undefined: no stall_cnt port and no counter logic.

Structure
REQ-030 Package hazard_pkg SHALL hold the FSM state enum (RUN=2'b00, MEMWAIT=2'b01, HALTED=2'b10), the MEM_LAT default, and the register-index width (4).
REQ-031 One sub-module, hazard_wait_timer, SHALL contain the load/decrement/zero-detect timer.

Verification
REQ-032 Load-use: idex load to R3, ifid SrcReg1=R3 -> pc_freeze=ifid_freeze=idex_flush=1 for 1 cycle; all 0 the next cycle once ID/EX holds the bubble.
REQ-033 R0 and store cases: idex load to R0 with SrcReg1=R0 -> no stall; idex store to R3 with SrcReg1=R3 -> no stall.
REQ-034 Branch plus load-use in the same cycle -> ifid_flush=idex_flush=1, pc_freeze=0.
REQ-035 mem_miss pulse with MEM_LAT=4 -> all_freeze high for exactly 4 cycles. A branch_taken held throughout produces flushes only in cycle 5.
REQ-036 halt_wb during MEMWAIT -> HALTED next cycle with halted=1 held. rst low mid-HALTED -> all outputs 0 asynchronously.
REQ-037 With HAZARD_STALL_CNT_EN defined, 3 load-use stalls plus one MEM_LAT=4 miss -> stall_cnt=7.
